issue_exec_stage_div: RTL and testbench

- Issue/execute stage for the integer-divide functional unit of the out-of-order core.
- Accepts one operand pair plus command/ROB tag from the divide reservation station.
- Runs a multicycle 64-bit unsigned iterative divider and presents the quotient with its tag/commands to the execution decision unit.
- Back-pressures the reservation station while busy or while the result is unconsumed.

---
 rtl/issue_exec_stage_div_if.sv | 34 +++
 rtl/issue_exec_stage_div.sv | 109 ++++++++++
 tb/tb_issue_exec_stage_div.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/issue_exec_stage_div_if.sv
// Bus between the divide reservation station, the divide issue/execute stage
// and the execution decision unit. The divider side uses the slave modport.
interface issue_exec_stage_div_if #(
   parameter int unsigned ROBsizeLog = 6
);
   logic [63:0]            reservationStationVal1_i;
   logic [63:0]            reservationStationVal2_i;
   logic [9:0]             reservationStationCommands_i;
   logic [ROBsizeLog-1:0]  reservationStationTag_i;
   logic                   readyRS_i;
   logic                   stallRS_o;
   logic                   canGo_i;
   logic [ROBsizeLog-1:0]  executeTag_o;
   logic [9:0]             executeCommands_o;
   logic [63:0]            executeVal_o;
   logic [3:0]             executeFlags_o;
   logic                   valid_o;

   modport master (
      output reservationStationVal1_i, reservationStationVal2_i,
             reservationStationCommands_i, reservationStationTag_i,
             readyRS_i, canGo_i,
      input  stallRS_o, executeTag_o, executeCommands_o, executeVal_o,
             executeFlags_o, valid_o
   );

   modport slave (
      input  reservationStationVal1_i, reservationStationVal2_i,
             reservationStationCommands_i, reservationStationTag_i,
             readyRS_i, canGo_i,
      output stallRS_o, executeTag_o, executeCommands_o, executeVal_o,
             executeFlags_o, valid_o
   );
endinterface

// File: rtl/issue_exec_stage_div.sv
// Issue/execute stage for the integer-divide unit: 64-bit unsigned restoring
// divider, one quotient bit per clock, 64 clocks from accept to result.
// Optional macro DIV_BY_ZERO_FLAG_EN: executeFlags_o[0] reports a zero divisor.
module issue_exec_stage_div #(
   parameter int unsigned ROBsize    = 32,
   parameter int unsigned ROBsizeLog = $clog2(ROBsize + 1)
) (
   input logic                   clk_i,
   input logic                   reset_i,
   issue_exec_stage_div_if.slave bus
);

   localparam int unsigned DataW = 64;
   localparam int unsigned CntW  = 7;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                 stateQ, stateD;
   logic [DataW-1:0]       quotQ;
   logic [DataW-1:0]       divisorQ;
   logic [DataW-1:0]       remQ;
   logic [CntW-1:0]        countQ;
   logic                   validQ;
   logic [ROBsizeLog-1:0]  tagQ;
   logic [9:0]             cmdQ;
   logic                   accept;
   logic [DataW:0]         remShift;
   logic [DataW-1:0]       remNext;
   logic                   quotBit;

   // Accept a new op when idle, or on the same edge the current result is consumed
   assign accept = bus.readyRS_i & ((stateQ == IDLE) | (validQ & bus.canGo_i));

   assign bus.stallRS_o         = ~accept;
   assign bus.valid_o           = validQ;
   assign bus.executeVal_o      = quotQ;
   assign bus.executeTag_o      = tagQ;
   assign bus.executeCommands_o = cmdQ;

   // State register
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) stateQ <= IDLE;
      else          stateQ <= stateD;
   end

   // Next-state logic
   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         IDLE:    if (bus.readyRS_i) stateD = BUSY;
         BUSY:    if (validQ & bus.canGo_i & ~bus.readyRS_i) stateD = IDLE;
         default: stateD = IDLE;
      endcase
   end

   // One restoring shift-subtract step; a zero divisor always subtracts, giving all ones
   always_comb begin
      remShift = {remQ, quotQ[DataW-1]};
      remNext  = remShift[DataW-1:0];
      quotBit  = 1'b0;
      if (remShift >= {1'b0, divisorQ}) begin
         remNext = DataW'(remShift - {1'b0, divisorQ});
         quotBit = 1'b1;
      end
   end

   // Operand capture, iteration and result hold
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         quotQ    <= '0;
         divisorQ <= '0;
         remQ     <= '0;
         countQ   <= '0;
         validQ   <= 1'b0;
         tagQ     <= '0;
         cmdQ     <= '0;
      end else if (accept) begin
         quotQ    <= bus.reservationStationVal1_i;
         divisorQ <= bus.reservationStationVal2_i;
         remQ     <= '0;
         countQ   <= CntW'(DataW);
         validQ   <= 1'b0;
         tagQ     <= bus.reservationStationTag_i;
         cmdQ     <= bus.reservationStationCommands_i;
      end else if (countQ != '0) begin
         quotQ  <= {quotQ[DataW-2:0], quotBit};
         remQ   <= remNext;
         countQ <= countQ - CntW'(1);
         if (countQ == CntW'(1)) validQ <= 1'b1;
      end else if (validQ & bus.canGo_i) begin
         validQ <= 1'b0;
      end
   end

`ifdef DIV_BY_ZERO_FLAG_EN
   logic zeroDivQ;

   // Remember whether the accepted op divides by zero
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i)    zeroDivQ <= 1'b0;
      else if (accept) zeroDivQ <= (bus.reservationStationVal2_i == '0);
   end

   assign bus.executeFlags_o = {3'b000, validQ & zeroDivQ};
`else
   assign bus.executeFlags_o = 4'b0000;
`endif

endmodule

// File: tb/tb_issue_exec_stage_div.sv
// Directed self-checking bench for issue_exec_stage_div (ROBsize = 8, 4-bit tags).
module tb_issue_exec_stage_div;

   logic clk_i;
   logic reset_i;
   int   total;
   int   bad;

`ifdef DIV_BY_ZERO_FLAG_EN
   localparam logic [3:0] ZeroFlagExp = 4'b0001;
`else
   localparam logic [3:0] ZeroFlagExp = 4'b0000;
`endif

   issue_exec_stage_div_if #(.ROBsizeLog(4)) bus ();

   issue_exec_stage_div #(.ROBsize(8), .ROBsizeLog(4)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .bus     (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Present an op with canGo high (consumes any pending result) and step past the accept edge
   task automatic issue(input logic [63:0] a, input logic [63:0] b,
                        input logic [9:0] c, input logic [3:0] t, input string nm);
      bus.reservationStationVal1_i     = a;
      bus.reservationStationVal2_i     = b;
      bus.reservationStationCommands_i = c;
      bus.reservationStationTag_i      = t;
      bus.readyRS_i = 1'b1;
      bus.canGo_i   = 1'b1;
      #1;
      total++;
      if (bus.stallRS_o !== 1'b0) begin
         bad++;
         $display("FAIL %s accept stall: got %b want 0", nm, bus.stallRS_o);
      end
      @(posedge clk_i); #1;
      bus.readyRS_i = 1'b0;
      bus.canGo_i   = 1'b0;
      total++;
      if (bus.executeTag_o !== t || bus.executeCommands_o !== c || bus.valid_o !== 1'b0) begin
         bad++;
         $display("FAIL %s load: tag %0d cmd %0d valid %b want tag %0d cmd %0d valid 0",
                  nm, bus.executeTag_o, bus.executeCommands_o, bus.valid_o, t, c);
      end
   endtask

   // Count edges from the accept until valid_o, bounded
   task automatic wait_done(input string nm, output int n);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk_i); #1;
         n++;
         if (bus.valid_o === 1'b1) break;
      end
      total++;
      if (n != 64 || bus.valid_o !== 1'b1) begin
         bad++;
         $display("FAIL %s latency: got %0d edges valid %b want 64 valid 1", nm, n, bus.valid_o);
      end
   endtask

   task automatic check_result(input logic [63:0] q, input logic [3:0] t,
                               input logic [3:0] f, input string nm);
      total++;
      if (bus.executeVal_o !== q || bus.executeTag_o !== t || bus.executeFlags_o !== f) begin
         bad++;
         $display("FAIL %s result: val %h tag %0d flags %b want val %h tag %0d flags %b",
                  nm, bus.executeVal_o, bus.executeTag_o, bus.executeFlags_o, q, t, f);
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b0;
      bus.readyRS_i = 1'b0;
      bus.canGo_i   = 1'b0;
      bus.reservationStationVal1_i     = '0;
      bus.reservationStationVal2_i     = '0;
      bus.reservationStationCommands_i = '0;
      bus.reservationStationTag_i      = '0;
      repeat (2) @(posedge clk_i);
      #1;
      total++;
      if (bus.valid_o !== 1'b0 || bus.executeVal_o !== 64'd0 || bus.executeTag_o !== 4'd0 ||
          bus.executeCommands_o !== 10'd0 || bus.stallRS_o !== 1'b1 || bus.executeFlags_o !== 4'd0) begin
         bad++;
         $display("FAIL reset: valid %b val %h tag %0d cmd %0d stall %b flags %b want 0 0 0 0 1 0",
                  bus.valid_o, bus.executeVal_o, bus.executeTag_o, bus.executeCommands_o,
                  bus.stallRS_o, bus.executeFlags_o);
      end
      reset_i = 1'b1;
      @(posedge clk_i); #1;
   endtask

   task automatic test_basic();
      int n;
      issue(64'd15, 64'd3, 10'd10, 4'd3, "basic");
      wait_done("basic", n);
      check_result(64'd5, 4'd3, 4'd0, "basic");
      total++;
      if (bus.stallRS_o !== 1'b1) begin
         bad++;
         $display("FAIL basic stall while unconsumed: got %b want 1", bus.stallRS_o);
      end
   endtask

   task automatic test_hold_consume();
      bus.canGo_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_i); #1;
         total++;
         if (bus.valid_o !== 1'b1 || bus.executeVal_o !== 64'd5 || bus.executeTag_o !== 4'd3 ||
             bus.executeCommands_o !== 10'd10) begin
            bad++;
            $display("FAIL hold cycle %0d: valid %b val %h tag %0d cmd %0d want 1 5 3 10",
                     i, bus.valid_o, bus.executeVal_o, bus.executeTag_o, bus.executeCommands_o);
         end
      end
      bus.canGo_i   = 1'b1;
      bus.readyRS_i = 1'b0;
      @(posedge clk_i); #1;
      bus.canGo_i = 1'b0;
      total++;
      if (bus.valid_o !== 1'b0 || bus.executeTag_o !== 4'd3) begin
         bad++;
         $display("FAIL consume: valid %b tag %0d want valid 0 tag 3", bus.valid_o, bus.executeTag_o);
      end
      // Idle again: a request is accepted even with canGo low
      bus.readyRS_i = 1'b1;
      #1;
      total++;
      if (bus.stallRS_o !== 1'b0) begin
         bad++;
         $display("FAIL idle after consume stall: got %b want 0", bus.stallRS_o);
      end
      bus.readyRS_i = 1'b0;
      @(posedge clk_i); #1;
   endtask

   task automatic test_back_to_back();
      int n;
      issue(64'd20, 64'd4, 10'd1, 4'd1, "b2b first");
      // A request while iterating is refused and its operands ignored
      repeat (5) @(posedge clk_i);
      #1;
      bus.reservationStationVal1_i = 64'd999;
      bus.reservationStationVal2_i = 64'd1;
      bus.reservationStationTag_i  = 4'd9;
      bus.readyRS_i = 1'b1;
      #1;
      total++;
      if (bus.stallRS_o !== 1'b1) begin
         bad++;
         $display("FAIL busy stall: got %b want 1", bus.stallRS_o);
      end
      @(posedge clk_i); #1;
      bus.readyRS_i = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (bus.valid_o === 1'b1) break;
         @(posedge clk_i); #1;
      end
      check_result(64'd5, 4'd1, 4'd0, "b2b first");
      issue(64'd100, 64'd7, 10'd77, 4'd5, "b2b second");
      wait_done("b2b second", n);
      check_result(64'd14, 4'd5, 4'd0, "b2b second");
   endtask

   task automatic test_div_zero_large();
      int n;
      issue(64'd42, 64'd0, 10'd3, 4'd2, "div0");
      wait_done("div0", n);
      check_result(64'hFFFF_FFFF_FFFF_FFFF, 4'd2, ZeroFlagExp, "div0");
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 10'd4, 4'd7, "large");
      wait_done("large", n);
      check_result(64'h7FFF_FFFF_FFFF_FFFF, 4'd7, 4'd0, "large");
      issue(64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 10'd5, 4'd6, "equal");
      wait_done("equal", n);
      check_result(64'd1, 4'd6, 4'd0, "equal");
   endtask

   task automatic test_reset_mid();
      int n;
      issue(64'd1000, 64'd10, 10'd8, 4'd4, "abort");
      repeat (30) @(posedge clk_i);
      #2;
      reset_i = 1'b0;
      #1;
      total++;
      if (bus.valid_o !== 1'b0 || bus.executeVal_o !== 64'd0 || bus.executeTag_o !== 4'd0 ||
          bus.executeCommands_o !== 10'd0) begin
         bad++;
         $display("FAIL mid reset: valid %b val %h tag %0d cmd %0d want all 0",
                  bus.valid_o, bus.executeVal_o, bus.executeTag_o, bus.executeCommands_o);
      end
      repeat (2) @(posedge clk_i);
      #3;
      reset_i = 1'b1;
      @(posedge clk_i); #1;
      total++;
      if (bus.valid_o !== 1'b0) begin
         bad++;
         $display("FAIL aborted op produced result: valid %b want 0", bus.valid_o);
      end
      issue(64'd9, 64'd3, 10'd2, 4'd1, "after reset");
      wait_done("after reset", n);
      check_result(64'd3, 4'd1, 4'd0, "after reset");
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_basic();
      test_hold_consume();
      test_back_to_back();
      test_div_zero_large();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
